// File: rtl/mul_arb_pkg.sv
// Shared configuration, tag/pick types and the round-robin search used by the
// multiplier-sharing arbiter.
package mul_arb_pkg;
  localparam int WIDTH   = 32;
  localparam int NREQ    = 4;
  localparam int LAT     = 2;
  localparam int MAX_REQ = 8;
  localparam int REQ_W   = $clog2(NREQ);
  localparam int CNT_W   = $clog2(LAT + 2);

  typedef struct packed {
    logic             v;
    logic [REQ_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic found;
    int   idx;
  } pick_t;

  // Scan from the far end back towards ptr so the nearest valid index wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input int ptr, input int n);
    pick_t r;
    int    idx;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (valid[idx]) begin
          r.found = 1'b1;
          r.idx   = idx;
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority pointer register plus combinational pick.
module rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int RW   = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [NREQ-1:0] valid_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [RW-1:0]   gnt_idx_o,
  output logic            gnt_vld_o
);
  logic [RW-1:0] ptr_q, ptr_d;
  pick_t         pick;

  always_comb begin
    pick      = rr_pick(MAX_REQ'(valid_i), int'(ptr_q), NREQ);
    gnt_idx_o = RW'(pick.idx);
    gnt_vld_o = pick.found & en_i;
    gnt_o     = '0;
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
    ptr_d = ptr_q;
    if (gnt_vld_o) ptr_d = (gnt_idx_o == RW'(NREQ - 1)) ? '0 : gnt_idx_o + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mul_share_arb.sv
// Shares one fixed-latency pipelined multiplier among NREQ requesters; tags
// each issue and steers the product back to its owner LAT+1 cycles later.
module mul_share_arb
  import mul_arb_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_mx,
  input  logic [NREQ*WIDTH-1:0]   req_my,
  output logic [WIDTH-1:0]        mul_mx,
  output logic [WIDTH-1:0]        mul_my,
  input  logic [2*WIDTH-1:0]      mul_product,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    busy
);
  logic [NREQ-1:0]  gnt;
  logic [REQ_W-1:0] gnt_idx;
  logic             issue;
  logic             rsp_v;

  logic [WIDTH-1:0] mx_q, mx_d, my_q, my_d;
  tag_t [LAT:0]     tag_q, tag_d;
  tag_t             tag_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Grants are masked while reset is held so req_ready reads zero throughout.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk_i     (CLK),
    .rst_i     (RST),
    .en_i      (en & ~RST),
    .valid_i   (req_valid),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (issue)
  );

  assign req_ready   = gnt;
  assign rsp_v       = tag_q[LAT].v;
  assign rsp_product = mul_product;
  assign mul_mx      = mx_q;
  assign mul_my      = my_q;
  assign busy        = (cnt_q != '0);

  always_comb begin
    mx_d = mx_q;
    my_d = my_q;
    if (issue) begin
      mx_d = req_mx[int'(gnt_idx)*WIDTH +: WIDTH];
      my_d = req_my[int'(gnt_idx)*WIDTH +: WIDTH];
    end
    tag_in.v  = issue;
    tag_in.id = gnt_idx;
    tag_d     = {tag_q[LAT-1:0], tag_in};
    unique case ({issue, rsp_v})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    rsp_valid = '0;
    if (rsp_v) rsp_valid[tag_q[LAT].id] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mx_q  <= '0;
      my_q  <= '0;
      tag_q <= '0;
      cnt_q <= '0;
    end else begin
      mx_q  <= mx_d;
      my_q  <= my_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based behavioural model.
module tb_mul_share_arb;
  import mul_arb_pkg::*;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  en  = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_mx = '0;
  logic [NREQ*WIDTH-1:0] req_my = '0;
  logic [WIDTH-1:0]      mul_mx, mul_my;
  logic [2*WIDTH-1:0]    mul_product;
  logic [NREQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]    rsp_product;
  logic                  busy;

  int checks = 0;
  int failures = 0;

  mul_share_arb dut (
    .CLK(CLK), .RST(RST), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_mx(req_mx), .req_my(req_my), .mul_mx(mul_mx), .mul_my(mul_my),
    .mul_product(mul_product), .rsp_valid(rsp_valid), .rsp_product(rsp_product),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Signed multiplier stand-in with LAT register stages, no stall.
  logic [2*WIDTH-1:0] mp [LAT];
  always @(posedge CLK) begin
    mp[0] <= $signed(mul_mx) * $signed(mul_my);
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_product = mp[LAT-1];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct {
    int          id;
    logic [63:0] prod;
    int          due;
  } ent_t;
  ent_t        q[$];
  int          mptr = 0;
  int          cyc = 0;
  logic [31:0] last_mx = '0, last_my = '0;

  always @(negedge CLK) begin
    int   widx;
    bit   found;
    ent_t e;
    if (RST) begin
      q.delete();
      mptr = 0;
      last_mx = '0;
      last_my = '0;
      chk("m_rst_rdy", 64'(req_ready), 64'd0);
      chk("m_rst_rsp", 64'(rsp_valid), 64'd0);
      chk("m_rst_busy", 64'(busy), 64'd0);
      chk("m_rst_mx", 64'(mul_mx), 64'd0);
    end else begin
      chk("m_busy", 64'(busy), 64'(q.size() != 0));
      chk("m_mx", 64'(mul_mx), 64'(last_mx));
      chk("m_my", 64'(mul_my), 64'(last_my));
      if (q.size() != 0 && q[0].due == cyc) begin
        chk("m_rsp_v", 64'(rsp_valid), 64'(1) << q[0].id);
        chk("m_rsp_p", rsp_product, q[0].prod);
        void'(q.pop_front());
      end else begin
        chk("m_rsp_idle", 64'(rsp_valid), 64'd0);
      end
      found = 0;
      widx  = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && en && req_valid[(mptr + k) % NREQ]) begin
          found = 1;
          widx  = (mptr + k) % NREQ;
        end
      end
      chk("m_ready", 64'(req_ready), found ? (64'(1) << widx) : 64'd0);
      if (found) begin
        last_mx = req_mx[widx*WIDTH +: WIDTH];
        last_my = req_my[widx*WIDTH +: WIDTH];
        e.id   = widx;
        e.prod = smul(last_mx, last_my);
        e.due  = cyc + LAT + 1;
        q.push_back(e);
        mptr = (widx + 1) % NREQ;
      end
    end
    cyc++;
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1; asserts reset mid-cycle, releases after the next edge.
  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_rdy", 64'(req_ready), 64'd0);
    @(negedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [31:0] mx, input logic [31:0] my);
    req_mx[i*WIDTH +: WIDTH] = mx;
    req_my[i*WIDTH +: WIDTH] = my;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("init_mx", 64'(mul_mx), 64'd0);
    chk("init_busy", 64'(busy), 64'd0);
    RST = 1'b0;
    en  = 1'b1;

    // Single requester: 7*6 back to requester 2 three cycles after issue.
    set_op(2, 32'd7, 32'd6);
    req_valid = 4'b0100;
    @(negedge CLK); chk("s_ready", 64'(req_ready), 64'h4);
    step(); req_valid = '0;
    @(negedge CLK); chk("s_busy1", 64'(busy), 64'd1); chk("s_mx", 64'(mul_mx), 64'd7);
    step();
    @(negedge CLK); chk("s_busy2", 64'(busy), 64'd1);
    step();
    @(negedge CLK);
    chk("s_rsp", 64'(rsp_valid), 64'h4);
    chk("s_prod", rsp_product, 64'd42);
    chk("s_busy3", 64'(busy), 64'd1);
    step();
    @(negedge CLK); chk("s_idle", 64'(busy), 64'd0); chk("s_rsp0", 64'(rsp_valid), 64'd0);

    // All four at once: grants 0..3, responses 10,20,30,40.
    step(); do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'd10);
    req_valid = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK);
      if (k < 4) chk("a_ready", 64'(req_ready), 64'(1) << k);
      if (k >= 3) begin
        chk("a_rsp", 64'(rsp_valid), 64'(1) << (k - 3));
        chk("a_prod", rsp_product, 64'((k - 2) * 10));
      end
      step();
      if (k < 4) req_valid[k] = 1'b0;
    end

    // Fairness: 0 and 3 alternate, pointer wraps 3 -> 0.
    do_reset();
    req_valid = 4'b1001;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("f_ready", 64'(req_ready), (k % 2) ? 64'h8 : 64'h1);
      step();
    end
    req_valid = '0;

    // Issue enable: blocked for four cycles, earlier response still returns.
    repeat (4) step();
    do_reset();
    set_op(1, 32'd3, 32'd5);
    req_valid = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      en = (k == 0 || k == 5);
      @(negedge CLK);
      chk("e_ready", 64'(req_ready), en ? 64'h2 : 64'h0);
      if (k == 3) begin
        chk("e_rsp", 64'(rsp_valid), 64'h2);
        chk("e_prod", rsp_product, 64'd15);
      end
      step();
    end
    req_valid = '0;
    en = 1'b1;

    // Reset with two operations in flight: neither ever responds.
    repeat (4) step();
    do_reset();
    req_valid = 4'b0001;
    step(); req_valid = 4'b0010;
    step(); req_valid = '0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); chk("r_norsp", 64'(rsp_valid), 64'd0);
      step();
    end
    req_valid = 4'b0110;
    @(negedge CLK); chk("r_first", 64'(req_ready), 64'h2);
    step(); req_valid = '0;

    // Signed extremes on requester 1.
    repeat (4) step();
    do_reset();
    set_op(1, 32'h8000_0000, 32'h8000_0000);
    req_valid = 4'b0010;
    @(negedge CLK); chk("x_ready", 64'(req_ready), 64'h2);
    step(); req_valid = '0;
    step(); step();
    @(negedge CLK);
    chk("x_rsp", 64'(rsp_valid), 64'h2);
    chk("x_prod", rsp_product, 64'h4000_0000_0000_0000);
    step();

    // Randomized traffic; the model process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      req_valid = NREQ'($urandom);
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) set_op(i, 32'h8000_0000, $urandom);
        else set_op(i, $urandom, $urandom);
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end
    req_valid = '0;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
